output_port_tx: RTL and testbench

Transmit side of one router output link. Registers the flit leaving the crossbar onto the link toward the downstream router. Tracks per-VC downstream state (idle, allocated, draining) and mirrors the downstream on/off flow control. Exports per-VC `is_on_o` to the switch allocator and `is_allocatable_o` to the VC allocator. One instance per output port, replicated by the enclosing output block.

---
 rtl/noc_params.sv | 32 +++
 rtl/vc_tx_fsm.sv | 51 +++++
 rtl/output_port_tx.sv | 80 ++++++++
 tb/tb_output_port_tx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_params.sv
// Shared router parameters and types: flit format, flit labels and the
// per-VC transmit state used by the output ports.
package noc_params;

   localparam int VC_NUM         = 4;
   localparam int VC_SIZE        = $clog2(VC_NUM);
   localparam int FLIT_DATA_SIZE = 16;

   typedef enum logic [1:0] {
      HEAD     = 2'd0,
      BODY     = 2'd1,
      TAIL     = 2'd2,
      HEADTAIL = 2'd3
   } flit_label_t;

   typedef struct packed {
      flit_label_t                flit_label;
      logic [VC_SIZE-1:0]         vc_id;
      logic [FLIT_DATA_SIZE-1:0]  data;
   } flit_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ALLOCATED = 2'd1,
      DRAINING  = 2'd2
   } vc_tx_state_t;

   function automatic logic is_tail_label(input flit_label_t label);
      return (label == TAIL) || (label == HEADTAIL);
   endfunction

endpackage

// File: rtl/vc_tx_fsm.sv
// Downstream state of one virtual channel as seen from the transmit side:
// IDLE until granted, ALLOCATED until its tail leaves, DRAINING until released.
module vc_tx_fsm
   import noc_params::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         grant,
   input  logic         tail,
   input  logic         flit,
   input  logic         vc_release,
   output vc_tx_state_t state,
   output logic         err
);

   vc_tx_state_t state_reg;
   vc_tx_state_t state_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Decisions use the state before this edge, so a grant and a flit on the
   // same idle VC both see IDLE: the grant lands and the flit is flagged.
   always_comb begin
      state_next = state_reg;
      err        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (grant) state_next = ALLOCATED;
            if (flit)  err        = 1'b1;
         end
         ALLOCATED: begin
            if (grant) err        = 1'b1;
            if (tail)  state_next = DRAINING;
         end
         DRAINING: begin
            if (grant || flit) err        = 1'b1;
            if (vc_release)    state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign state = state_reg;

endmodule

// File: rtl/output_port_tx.sv
// Transmit side of one router output link: output flit register, on/off
// mirror, per-VC downstream state tracking and a sticky protocol-error flag.
module output_port_tx
   import noc_params::*;
(
   input  logic              clk,
   input  logic              rst,
   input  flit_t             flit_i,
   input  logic              valid_flit_i,
   input  logic [VC_NUM-1:0] on_off_i,
   input  logic [VC_NUM-1:0] vc_allocatable_i,
   input  logic [VC_NUM-1:0] vc_alloc_i,
   output flit_t             data_o,
   output logic              valid_flit_o,
   output logic [VC_NUM-1:0] is_on_o,
   output logic [VC_NUM-1:0] is_allocatable_o,
   output logic              error_o
);

   flit_t             data_reg;
   logic              valid_reg;
   logic [VC_NUM-1:0] is_on_reg;
   logic              error_reg;
   logic              error_next;

   logic              multi_grant;
   logic              flit_is_tail;
   logic              off_err;
   logic [VC_NUM-1:0] fsm_err;
   vc_tx_state_t      vc_state [VC_NUM];

   assign multi_grant  = ($countones(vc_alloc_i) > 1);
   assign flit_is_tail = is_tail_label(flit_i.flit_label);
   assign off_err      = valid_flit_i && !is_on_reg[flit_i.vc_id];

   // A malformed grant vector freezes every VC for the cycle; flits are
   // still checked against the unchanged state.
   generate
      for (genvar gi = 0; gi < VC_NUM; gi++) begin : g_vc
         logic flit_here;

         assign flit_here = valid_flit_i && (flit_i.vc_id == VC_SIZE'(gi));

         vc_tx_fsm u_fsm (
            .clk        (clk),
            .rst        (rst),
            .grant      (vc_alloc_i[gi] && !multi_grant),
            .tail       (flit_here && flit_is_tail && !multi_grant),
            .flit       (flit_here),
            .vc_release (vc_allocatable_i[gi] && !multi_grant),
            .state      (vc_state[gi]),
            .err        (fsm_err[gi])
         );

         assign is_allocatable_o[gi] = (vc_state[gi] == IDLE);
      end
   endgenerate

   assign error_next = error_reg || (|fsm_err) || multi_grant || off_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         data_reg  <= '0;
         valid_reg <= 1'b0;
         is_on_reg <= '1;
         error_reg <= 1'b0;
      end else begin
         valid_reg <= valid_flit_i;
         if (valid_flit_i) data_reg <= flit_i;
         is_on_reg <= on_off_i;
         error_reg <= error_next;
      end
   end

   assign data_o       = data_reg;
   assign valid_flit_o = valid_reg;
   assign is_on_o      = is_on_reg;
   assign error_o      = error_reg;

endmodule

// File: tb/tb_output_port_tx.sv
// Self-checking bench for output_port_tx: directed scenarios plus a random
// run, all checked against a cycle-level behavioural model of the link.
module tb_output_port_tx;
   import noc_params::*;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   flit_t             flit_i = '0;
   logic              valid_flit_i = 1'b0;
   logic [VC_NUM-1:0] on_off_i = '1;
   logic [VC_NUM-1:0] vc_allocatable_i = '0;
   logic [VC_NUM-1:0] vc_alloc_i = '0;
   flit_t             data_o;
   logic              valid_flit_o;
   logic [VC_NUM-1:0] is_on_o;
   logic [VC_NUM-1:0] is_allocatable_o;
   logic              error_o;

   int total = 0;
   int bad   = 0;

   // Model: per VC 0 = free, 1 = owned by a packet, 2 = waiting for release.
   int                m_state [VC_NUM] = '{default: 0};
   logic              m_err   = 1'b0;
   logic              m_valid = 1'b0;
   flit_t             m_data  = '0;
   logic [VC_NUM-1:0] m_on    = '1;

   output_port_tx dut (
      .clk              (clk),
      .rst              (rst),
      .flit_i           (flit_i),
      .valid_flit_i     (valid_flit_i),
      .on_off_i         (on_off_i),
      .vc_allocatable_i (vc_allocatable_i),
      .vc_alloc_i       (vc_alloc_i),
      .data_o           (data_o),
      .valid_flit_o     (valid_flit_o),
      .is_on_o          (is_on_o),
      .is_allocatable_o (is_allocatable_o),
      .error_o          (error_o)
   );

   always #5 clk = ~clk;

   function automatic logic [VC_NUM-1:0] m_free();
      logic [VC_NUM-1:0] r;
      for (int v = 0; v < VC_NUM; v++) r[v] = (m_state[v] == 0);
      return r;
   endfunction

   // Apply the current inputs to the model, then clock the DUT.
   task automatic step();
      int n;
      int nxt [VC_NUM];
      n = $countones(vc_alloc_i);
      if (rst) begin
         for (int v = 0; v < VC_NUM; v++) m_state[v] = 0;
         m_err = 1'b0; m_valid = 1'b0; m_data = '0; m_on = '1;
      end else begin
         for (int v = 0; v < VC_NUM; v++) nxt[v] = m_state[v];
         if (n > 1) m_err = 1'b1;
         if (valid_flit_i && !m_on[flit_i.vc_id]) m_err = 1'b1;
         if (valid_flit_i && m_state[flit_i.vc_id] != 1) m_err = 1'b1;
         if (n <= 1) begin
            for (int v = 0; v < VC_NUM; v++) begin
               if (vc_alloc_i[v]) begin
                  if (m_state[v] == 0) nxt[v] = 1;
                  else m_err = 1'b1;
               end
               if (valid_flit_i && flit_i.vc_id == v && m_state[v] == 1 &&
                   (flit_i.flit_label == TAIL || flit_i.flit_label == HEADTAIL))
                  nxt[v] = 2;
               if (vc_allocatable_i[v] && m_state[v] == 2) nxt[v] = 0;
            end
         end
         for (int v = 0; v < VC_NUM; v++) m_state[v] = nxt[v];
         m_valid = valid_flit_i;
         if (valid_flit_i) m_data = flit_i;
         m_on = on_off_i;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      valid_flit_i = 1'b0; vc_alloc_i = '0; vc_allocatable_i = '0; on_off_i = '1;
   endtask

   task automatic send(input flit_label_t lbl, input int vc);
      flit_i.flit_label = lbl;
      flit_i.vc_id      = VC_SIZE'(vc);
      flit_i.data       = FLIT_DATA_SIZE'($urandom);
      valid_flit_i      = 1'b1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1; step(); step(); rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (is_allocatable_o !== 4'hF) begin bad++; $display("FAIL reset_alloc got=%b exp=1111", is_allocatable_o); end
      total++; if (is_on_o !== 4'hF) begin bad++; $display("FAIL reset_on got=%b exp=1111", is_on_o); end
      total++; if (valid_flit_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_flit_o); end
      total++; if (error_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", error_o); end
      total++; if (data_o !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", data_o); end
   endtask

   task automatic test_packet_vc1();
      flit_label_t lbls [3] = '{HEAD, BODY, TAIL};
      do_reset();
      vc_alloc_i = 4'b0010; step(); vc_alloc_i = '0;
      total++; if (is_allocatable_o[1] !== 1'b0) begin bad++; $display("FAIL pkt_grant alloc1 got=%b exp=0", is_allocatable_o[1]); end
      for (int i = 0; i < 3; i++) begin
         send(lbls[i], 1); step();
         total++; if (valid_flit_o !== 1'b1 || data_o !== m_data) begin bad++; $display("FAIL pkt_flit%0d got=%h/%b exp=%h/1", i, data_o, valid_flit_o, m_data); end
      end
      valid_flit_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         total++; if (is_allocatable_o[1] !== 1'b0 || valid_flit_o !== 1'b0) begin bad++; $display("FAIL pkt_drain%0d alloc1=%b valid=%b exp=0/0", i, is_allocatable_o[1], valid_flit_o); end
      end
      vc_allocatable_i = 4'b0010; step(); vc_allocatable_i = '0;
      total++; if (is_allocatable_o !== 4'hF) begin bad++; $display("FAIL pkt_release got=%b exp=1111", is_allocatable_o); end
      total++; if (error_o !== 1'b0) begin bad++; $display("FAIL pkt_err got=%b exp=0", error_o); end
   endtask

   task automatic test_headtail_release();
      do_reset();
      vc_alloc_i = 4'b0001; step(); vc_alloc_i = '0;
      send(HEADTAIL, 0); vc_allocatable_i = 4'b0001; step();
      valid_flit_i = 1'b0;
      total++; if (is_allocatable_o[0] !== 1'b0) begin bad++; $display("FAIL ht_same_cycle alloc0 got=%b exp=0", is_allocatable_o[0]); end
      step(); vc_allocatable_i = '0;
      total++; if (is_allocatable_o[0] !== 1'b1) begin bad++; $display("FAIL ht_release alloc0 got=%b exp=1", is_allocatable_o[0]); end
      total++; if (error_o !== 1'b0) begin bad++; $display("FAIL ht_err got=%b exp=0", error_o); end
   endtask

   task automatic test_flow_mirror();
      do_reset();
      on_off_i = 4'b1011; step();
      total++; if (is_on_o !== 4'b1011) begin bad++; $display("FAIL flow_1011 got=%b exp=1011", is_on_o); end
      for (int i = 0; i < 6; i++) begin
         on_off_i = VC_NUM'($urandom); step();
         total++; if (is_on_o !== m_on) begin bad++; $display("FAIL flow_rand%0d got=%b exp=%b", i, is_on_o, m_on); end
      end
      on_off_i = '1;
   endtask

   task automatic test_errors();
      do_reset();
      vc_alloc_i = 4'b0100; step(); step(); vc_alloc_i = '0;
      total++; if (error_o !== 1'b1) begin bad++; $display("FAIL err_regrant got=%b exp=1", error_o); end
      step();
      total++; if (error_o !== 1'b1 || is_allocatable_o[2] !== 1'b0) begin bad++; $display("FAIL err_sticky err=%b alloc2=%b exp=1/0", error_o, is_allocatable_o[2]); end
      do_reset();
      vc_alloc_i = 4'b0110; step(); vc_alloc_i = '0;
      total++; if (error_o !== 1'b1 || is_allocatable_o !== 4'hF) begin bad++; $display("FAIL err_multi err=%b alloc=%b exp=1/1111", error_o, is_allocatable_o); end
      do_reset();
      send(BODY, 3); step(); valid_flit_i = 1'b0;
      total++; if (error_o !== 1'b1 || data_o !== m_data || valid_flit_o !== 1'b1) begin bad++; $display("FAIL err_idle_flit err=%b data=%h exp=1/%h", error_o, data_o, m_data); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      vc_alloc_i = 4'b0100; step(); vc_alloc_i = '0;
      send(HEAD, 2); step();
      send(BODY, 2); rst = 1'b1; step(); rst = 1'b0; valid_flit_i = 1'b0;
      total++; if (is_allocatable_o !== 4'hF || valid_flit_o !== 1'b0) begin bad++; $display("FAIL midrst alloc=%b valid=%b exp=1111/0", is_allocatable_o, valid_flit_o); end
      vc_alloc_i = 4'b0100; step(); vc_alloc_i = '0;
      total++; if (error_o !== 1'b0 || is_allocatable_o !== 4'b1011) begin bad++; $display("FAIL midrst_regrant err=%b alloc=%b exp=0/1011", error_o, is_allocatable_o); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rst = (c % 60 == 59);
         vc_alloc_i = '0;
         case ($urandom_range(0, 9))
            6, 7, 8: vc_alloc_i[$urandom_range(0, VC_NUM-1)] = 1'b1;
            9:       vc_alloc_i = VC_NUM'($urandom);
            default: ;
         endcase
         valid_flit_i = ($urandom_range(0, 9) < 6);
         flit_i.flit_label = flit_label_t'($urandom_range(0, 3));
         flit_i.vc_id      = VC_SIZE'($urandom_range(0, VC_NUM-1));
         flit_i.data       = FLIT_DATA_SIZE'($urandom);
         for (int v = 0; v < VC_NUM; v++) begin
            on_off_i[v]         = ($urandom_range(0, 3) != 0);
            vc_allocatable_i[v] = ($urandom_range(0, 3) == 0);
         end
         step();
         total++;
         if (data_o !== m_data || valid_flit_o !== m_valid || is_on_o !== m_on ||
             is_allocatable_o !== m_free() || error_o !== m_err) begin
            bad++;
            $display("FAIL rnd cyc=%0d got d=%h v=%b on=%b al=%b e=%b exp d=%h v=%b on=%b al=%b e=%b",
                     c, data_o, valid_flit_o, is_on_o, is_allocatable_o, error_o,
                     m_data, m_valid, m_on, m_free(), m_err);
         end
      end
      rst = 1'b0;
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_packet_vc1();
      test_headtail_release();
      test_flow_mirror();
      test_errors();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
